// File: rtl/apb_pkg.sv
// Shared types and sizes for the APB master bridge.
package apb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam logic [31:0] SLV_SIZE = 32'h1000;
  localparam int unsigned PAGE_LSB = $clog2(SLV_SIZE);
  localparam int unsigned PAGE_W   = ADDR_W - PAGE_LSB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } apb_state_e;

  // Request as captured from the CPU port when a transfer is accepted
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the 4 KiB page of a byte address onto a slave slot of the APB window.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  localparam int unsigned SEL_W    = clog2_min1(NUM_SLV)
) (
  input  logic [PAGE_W-1:0]  page,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_SLV-1:0] psel,
  output logic               hit
);

  logic [PAGE_W-1:0] diff;

  // Unsigned wrap makes pages below the base land far above NUM_SLV
  always_comb begin
    diff = page - BASE_ADDR[ADDR_W-1:PAGE_LSB];
    hit  = (diff < PAGE_W'(NUM_SLV));
    sel  = SEL_W'(diff);
    psel = hit ? (NUM_SLV'(1) << sel) : '0;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns single CPU load/store requests into SETUP/ACCESS
// transfers on one of NUM_SLV slaves, with unmapped-address and timeout errors.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY
);

  localparam int unsigned SEL_W    = clog2_min1(NUM_SLV);
  localparam int unsigned CNT_W    = clog2_min1(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e         state_q, state_d;
  apb_req_t           req_q, req_d;
  logic [SEL_W-1:0]   sel_q, sel_d, dec_sel;
  logic [NUM_SLV-1:0] psel_q, psel_d, dec_psel;
  logic               dec_hit;
  logic               penable_q, penable_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  slv_rdata;
  logic               slv_ready;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR)
  ) u_dec (
    .page (addr[ADDR_W-1:PAGE_LSB]),
    .sel  (dec_sel),
    .psel (dec_psel),
    .hit  (dec_hit)
  );

  // Response of the slave latched at acceptance; other slaves are ignored
  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (SEL_W'(i) == sel_q) begin
        slv_rdata = PRDATA[DATA_W*i +: DATA_W];
        slv_ready = PREADY[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sel_d     = sel_q;
    psel_d    = '0;
    penable_d = 1'b0;
    cnt_d     = '0;
    ready     = 1'b0;
    err       = 1'b0;
    rdata     = '0;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          req_d = '{write, addr, wdata};
          sel_d = dec_sel;
          if (dec_hit) begin
            state_d = SETUP;
            psel_d  = dec_psel;
          end else begin
            state_d = ERROR;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = psel_q;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (slv_ready) begin
          ready   = 1'b1;
          rdata   = req_q.write ? '0 : slv_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          psel_d    = psel_q;
          penable_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= IDLE;
      req_q     <= '0;
      sel_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign PADDR   = req_q.addr;
  assign PWDATA  = req_q.wdata;
  assign PWRITE  = req_q.write;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: RAM slave plus wait-state slaves,
// directed corner cases then random traffic against a transaction-level model.
module tb_apb_master_bridge;

  localparam int unsigned NS    = 4;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned TO    = 16;
  localparam int unsigned NEVER = 255;
  localparam int unsigned CW    = 128;

  logic           PCLK = 1'b0;
  logic           PRESET = 1'b0;
  logic           transfer = 1'b0;
  logic           write = 1'b0;
  logic [31:0]    addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata, PADDR, PWDATA;
  logic           ready, err, busy, PWRITE, PENABLE;
  logic [NS-1:0]  PSEL, PREADY;
  logic [NS*32-1:0] PRDATA;

  int checks = 0;
  int errors = 0;

  bit [31:0]   ram [0:1023];
  bit [31:0]   mdl_mem [0:1023];
  bit          ram_rdy;
  bit [31:0]   ram_q;
  int unsigned waitv [NS];
  int unsigned acc [NS];
  bit [31:0]   slv_data [NS];
  bit [NS-1:0] nz_rdy;
  bit [NS*32-1:0] nz_data;

  apb_master_bridge #(.NUM_SLV(NS), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .busy(busy), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Slave environment: slot 0 is a registered-PREADY RAM, slots 1.. assert
  // PREADY after waitv[i] extra ACCESS cycles; unselected lanes carry noise.
  always @(posedge PCLK) begin
    nz_rdy  <= NS'($urandom);
    nz_data <= {$urandom, $urandom, $urandom, $urandom};
    if (PSEL[0] && PENABLE && !ram_rdy) begin
      ram_rdy <= 1'b1;
      if (PWRITE) ram[PADDR[11:2]] <= PWDATA;
      ram_q <= ram[PADDR[11:2]];
    end else begin
      ram_rdy <= 1'b0;
    end
    for (int i = 1; i < NS; i++) acc[i] <= (PSEL[i] && PENABLE) ? acc[i] + 1 : 0;
  end

  always_comb begin
    PREADY = nz_rdy;
    PRDATA = nz_data;
    if (PSEL[0]) begin
      PREADY[0]    = ram_rdy;
      PRDATA[31:0] = ram_q;
    end
    for (int i = 1; i < NS; i++) begin
      if (PSEL[i]) begin
        PREADY[i]         = PENABLE && (acc[i] == waitv[i]);
        PRDATA[32*i +: 32] = slv_data[i];
      end
    end
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction model: ready cycle k (1 = first cycle after acceptance), err, rdata, PSEL
  task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       output int k, output logic e, output logic [31:0] rd,
                       output logic [NS-1:0] ps);
    int unsigned pg, w;
    pg = (a - BASE) >> 12;
    e = 1'b0; rd = '0; ps = '0; k = 1;
    if (pg >= NS) begin
      e = 1'b1;
      return;
    end
    ps = NS'(1 << pg);
    if (pg == 0) begin
      k = 3;
      if (wr) mdl_mem[a[11:2]] = wd;
      else    rd = mdl_mem[a[11:2]];
      return;
    end
    w = waitv[pg];
    if (w + 1 <= TO) begin
      k  = 2 + int'(w);
      rd = wr ? 32'h0 : slv_data[pg];
    end else begin
      k = 1 + int'(TO);
      e = 1'b1;
    end
  endtask

  // Called at a falling edge in an IDLE cycle; returns at a falling edge in IDLE
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int k;
    logic e;
    logic [31:0] rd;
    logic [NS-1:0] ps;
    int n;
    model(wr, a, wd, k, e, rd, ps);
    check("idle_before", CW'(busy), CW'(0));
    transfer = 1'b1; write = wr; addr = a; wdata = wd;
    for (int c = 1; c <= k; c++) begin
      @(negedge PCLK);
      check("bus_latch", CW'({PADDR, PWDATA, PWRITE}), CW'({a, wd, wr}));
      check("ctrl", CW'({ready, busy, PSEL, PENABLE}),
            CW'({c == k, 1'b1, ps, (ps != 0) && (c >= 2)}));
      if (c == k) check("resp", CW'({err, rdata}), CW'({e, rd}));
      transfer = 1'($urandom);
      write    = 1'($urandom);
      addr     = BASE + 32'($urandom_range(0, NS - 1)) * 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      wdata    = $urandom;
    end
    @(negedge PCLK);
    transfer = 1'b0;
    check("idle_after", CW'({ready, busy, PSEL, PENABLE}), CW'(0));
    if (busy) begin
      n = 0;
      while (busy && n < 64) begin
        @(negedge PCLK);
        n++;
      end
      check("resync", CW'(busy), CW'(0));
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned kind;

    for (int i = 0; i < NS; i++) begin
      waitv[i] = 2;
      slv_data[i] = 32'hA5A5_0000 | 32'(i);
    end

    // Reset values
    repeat (2) @(negedge PCLK);
    check("reset_outputs",
          CW'({rdata, ready, err, busy, PADDR, PWDATA, PWRITE, PENABLE, PSEL}), CW'(0));
    PRESET = 1'b1;
    @(negedge PCLK);

    // RAM write then read-back
    xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF);
    check("ram_word4", CW'(ram[4]), CW'(32'hDEAD_BEEF));
    xfer(1'b0, 32'h1000_0010, $urandom);

    // Slave 3 never ready: timeout
    waitv[3] = NEVER;
    xfer(1'b0, 32'h1000_3004, $urandom);

    // Unmapped addresses, including both edges of the window
    xfer(1'b0, 32'h2000_0000, $urandom);
    xfer(1'b1, 32'h0FFF_FFFC, $urandom);
    xfer(1'b0, 32'h1000_4000, $urandom);

    // Last mapped word, zero-wait slave, timeout boundary on both sides
    waitv[3] = 1;  slv_data[3] = 32'h3333_CAFE;
    xfer(1'b0, 32'h1000_3FFC, $urandom);
    waitv[1] = 0;  slv_data[1] = 32'h1111_0001;
    xfer(1'b0, 32'h1000_1000, $urandom);
    waitv[1] = TO - 1; slv_data[1] = 32'h1111_0F0F;
    xfer(1'b0, 32'h1000_1008, $urandom);
    waitv[2] = TO;
    xfer(1'b0, 32'h1000_2000, $urandom);
    waitv[2] = 3;
    xfer(1'b1, 32'h1000_2010, $urandom);

    // Reset in the middle of ACCESS abandons the transfer
    waitv[3] = NEVER;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_3008; wdata = $urandom;
    @(negedge PCLK);
    transfer = 1'b0;
    repeat (3) @(negedge PCLK);
    check("pre_reset_access", CW'({busy, PENABLE, PSEL}), CW'({1'b1, 1'b1, 4'b1000}));
    PRESET = 1'b0;
    #1;
    check("reset_mid_access", CW'({ready, busy, PSEL, PENABLE}), CW'(0));
    @(negedge PCLK);
    check("reset_held", CW'({ready, busy, PSEL, PENABLE, PADDR}), CW'(0));
    PRESET = 1'b1;
    @(negedge PCLK);
    check("after_reset_idle", CW'({ready, busy}), CW'(0));
    xfer(1'b0, 32'h1000_0010, $urandom);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      for (int i = 1; i < NS; i++) begin
        waitv[i]    = $urandom_range(0, TO + 2);
        slv_data[i] = $urandom;
      end
      if (kind == 0)      a = $urandom;
      else if (kind <= 5) a = BASE + 32'($urandom_range(0, 7)) * 4;
      else                a = BASE + 32'($urandom_range(1, NS - 1)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
      xfer(1'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
